// File: rtl/desired_drive_slew.sv
// desired_drive_slew: three-stage pipeline that turns filtered pedal torque, cadence,
// incline and assist level into a motor current target.
// Stage 1 registers the torque and incline/cadence terms.
// Stage 2 registers their product; the product is forced to zero when not pedaling.
// Stage 3 moves target_curr toward the saturated raw current.
// Optional macro DESIRED_DRIVE_SLEW_LIMIT_EN: when defined, target_curr moves by at most
// SLEW_UP / SLEW_DN per sample. When undefined, target_curr jumps straight to raw.
module desired_drive_slew #(
    parameter logic [11:0] TORQUE_MIN = 12'h380,
    parameter logic [4:0]  CAD_THRESH = 5'd1,
    parameter logic [11:0] SLEW_UP    = 12'h100,
    parameter logic [11:0] SLEW_DN    = 12'h200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld,
    input  logic [11:0] avg_torque,
    input  logic [4:0]  cadence,
    input  logic        not_pedaling,
    input  logic [12:0] incline,
    input  logic [2:0]  scale,
    output logic [11:0] target_curr,
    output logic        out_vld,
    output logic        at_target
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RAMP = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // valid pipe
    logic        v1_q;
    logic        v2_q;

    // stage registers
    logic [14:0] s1_torque_q;
    logic [14:0] s1_incline_q;
    logic        s1_np_q;
    logic [29:0] s2_prod_q;
    logic        s2_np_q;
    logic [1:0]  state_q;

    // stage-1 combinational terms
    logic [11:0]        torque_off;
    logic [14:0]        torque_pos;
    logic signed [12:0] inc_s;
    logic signed [12:0] inc_sat;
    logic signed [12:0] inc_off;
    logic [8:0]         incline_lim;
    logic [5:0]         cad_factor;
    logic [14:0]        incline_term;

    // stage-3 combinational terms
    logic [11:0] raw_curr;
    logic [11:0] target_new;
    logic [1:0]  state_new;
    logic        go_idle;

    // Stage-1 arithmetic: torque above the offset, and the incline/cadence factor
    always_comb begin
        torque_off   = (avg_torque > TORQUE_MIN) ? (avg_torque - TORQUE_MIN) : 12'd0;
        torque_pos   = {3'd0, torque_off} * {12'd0, scale};
        inc_s        = $signed(incline);
        if (inc_s > 13'sd511) begin
            inc_sat = 13'sd511;
        end else if (inc_s < -13'sd512) begin
            inc_sat = -13'sd512;
        end else begin
            inc_sat = inc_s;
        end
        inc_off = inc_sat + 13'sd256;
        if (inc_off < 13'sd0) begin
            incline_lim = 9'd0;
        end else if (inc_off > 13'sd511) begin
            incline_lim = 9'd511;
        end else begin
            incline_lim = inc_off[8:0];
        end
        cad_factor   = (cadence > CAD_THRESH) ? ({1'b0, cadence} + 6'd32) : 6'd0;
        incline_term = {6'd0, incline_lim} * {9'd0, cad_factor};
    end

    // Raw current saturates once the product exceeds the 12-bit window
    always_comb begin
        raw_curr = (|s2_prod_q[29:27]) ? 12'hFFF : s2_prod_q[26:15];
    end

`ifdef DESIRED_DRIVE_SLEW_LIMIT_EN
    logic [12:0] raw_x;
    logic [12:0] tgt_x;
    logic [12:0] up_diff;
    logic [12:0] dn_diff;
    logic [12:0] up_step;
    logic [12:0] dn_step;
    logic [12:0] up_sum;
    logic [12:0] dn_sum;

    // Slew-limited step toward raw; 13-bit sums clamp rather than wrap
    always_comb begin
        raw_x   = {1'b0, raw_curr};
        tgt_x   = {1'b0, target_curr};
        up_diff = raw_x - tgt_x;
        dn_diff = tgt_x - raw_x;
        up_step = (up_diff > {1'b0, SLEW_UP}) ? {1'b0, SLEW_UP} : up_diff;
        dn_step = (dn_diff > {1'b0, SLEW_DN}) ? {1'b0, SLEW_DN} : dn_diff;
        up_sum  = tgt_x + up_step;
        dn_sum  = tgt_x - dn_step;
        if (raw_x > tgt_x) begin
            target_new = up_sum[12] ? 12'hFFF : up_sum[11:0];
        end else if (raw_x < tgt_x) begin
            target_new = dn_sum[12] ? 12'h000 : dn_sum[11:0];
        end else begin
            target_new = target_curr;
        end
    end

    // Next FSM state for the sample in stage 3
    always_comb begin
        go_idle = (raw_curr == 12'd0) && (target_new == 12'd0) && s2_np_q;
        if (go_idle) begin
            state_new = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            state_new = (raw_curr == 12'd0) ? ST_HOLD : ST_RAMP;
        end else begin
            state_new = (target_new == raw_curr) ? ST_HOLD : ST_RAMP;
        end
    end
`else
    // Unlimited: target follows raw and the FSM never lingers in RAMP
    always_comb begin
        target_new = raw_curr;
        go_idle    = (raw_curr == 12'd0) && s2_np_q;
        state_new  = go_idle ? ST_IDLE : ST_HOLD;
    end
`endif

    // Valid pipe: out_vld is the third stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            v1_q    <= in_vld;
            v2_q    <= v1_q;
            out_vld <= v2_q;
        end
    end

    // Stage 1: capture the two factors and the pedaling flag on each sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_torque_q  <= 15'd0;
            s1_incline_q <= 15'd0;
            s1_np_q      <= 1'b0;
        end else if (in_vld) begin
            s1_torque_q  <= torque_pos;
            s1_incline_q <= incline_term;
            s1_np_q      <= not_pedaling;
        end
    end

    // Stage 2: full product, zeroed for samples taken while not pedaling
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_prod_q <= 30'd0;
            s2_np_q   <= 1'b0;
        end else if (v1_q) begin
            s2_prod_q <= s1_np_q ? 30'd0 : ({15'd0, s1_torque_q} * {15'd0, s1_incline_q});
            s2_np_q   <= s1_np_q;
        end
    end

    // Stage 3: update target and FSM only on a valid stage-3 sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_curr <= 12'd0;
            state_q     <= ST_IDLE;
        end else if (v2_q) begin
            target_curr <= target_new;
            state_q     <= state_new;
        end
    end

    assign at_target = (state_q == ST_HOLD);

endmodule

// File: tb/tb_desired_drive_slew.sv
// Self-checking bench for desired_drive_slew: table of converged-target vectors,
// hand sequences for ramp/decay/latency/reset, and random stimulus against a model.
module tb_desired_drive_slew;

    localparam int TMIN = 'h380;
    localparam int CTH  = 1;
`ifdef DESIRED_DRIVE_SLEW_LIMIT_EN
    localparam int SUP  = 'h100;
    localparam int SDN  = 'h200;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld;
    logic [11:0] avg_torque;
    logic [4:0]  cadence;
    logic        not_pedaling;
    logic [12:0] incline;
    logic [2:0]  scale;
    logic [11:0] target_curr;
    logic        out_vld;
    logic        at_target;

    always #5 clk = ~clk;

    desired_drive_slew dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vld       (in_vld),
        .avg_torque   (avg_torque),
        .cadence      (cadence),
        .not_pedaling (not_pedaling),
        .incline      (incline),
        .scale        (scale),
        .target_curr  (target_curr),
        .out_vld      (out_vld),
        .at_target    (at_target)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int due;
        int raw;
        bit np;
    } samp_t;
    samp_t q[$];

    // Model: 0 idle, 1 ramping, 2 holding
    int m_tgt   = 0;
    int m_state = 0;
    int k       = 0;

    typedef struct {
        logic [11:0] avg;
        logic [2:0]  sc;
        logic [12:0] inc;
        logic [4:0]  cad;
        logic        np;
        logic [11:0] exp_tgt;
        logic        exp_at;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, k, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int calc_raw(input int avg, input int sc, input int inc, input int cad,
                                    input bit np);
        int tp, il, cf, p;
        if (np) return 0;
        tp = ((avg > TMIN) ? (avg - TMIN) : 0) * sc;
        il = clampi(clampi(inc, -512, 511) + 256, 0, 511);
        cf = (cad > CTH) ? cad + 32 : 0;
        p  = tp * il * cf;
        if (p >= (1 << 27)) return 'hFFF;
        return p / 32768;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_update(input int raw, input bit np);
        int nt;
`ifdef DESIRED_DRIVE_SLEW_LIMIT_EN
        if (raw > m_tgt) nt = m_tgt + min2(raw - m_tgt, SUP);
        else if (raw < m_tgt) nt = m_tgt - min2(m_tgt - raw, SDN);
        else nt = m_tgt;
        if (raw == 0 && nt == 0 && np) m_state = 0;
        else if (m_state == 0) m_state = (raw == 0) ? 2 : 1;
        else m_state = (nt == raw) ? 2 : 1;
`else
        nt = raw;
        m_state = (raw == 0 && np) ? 0 : 2;
`endif
        m_tgt = nt;
    endtask

    // One clock: update the model with what the DUT sampled, then check outputs
    task automatic step();
        bit    exp_vld;
        samp_t s;
        @(posedge clk);
        k++;
        exp_vld = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_tgt   = 0;
            m_state = 0;
        end else begin
            if (in_vld)
                q.push_back('{k + 2, calc_raw(avg_torque, scale, $signed(incline), cadence,
                                             not_pedaling), not_pedaling});
            if (q.size() > 0 && q[0].due == k) begin
                s = q.pop_front();
                model_update(s.raw, s.np);
                exp_vld = 1'b1;
            end
        end
        #1;
        check("out_vld", out_vld, exp_vld);
        check("target_curr", target_curr, m_tgt);
        check("at_target", at_target, (m_state == 2) ? 1 : 0);
    endtask

    task automatic drive(input logic [11:0] a, input logic [2:0] s, input logic [12:0] i,
                         input logic [4:0] c, input logic np, input logic v);
        avg_torque   = a;
        scale        = s;
        incline      = i;
        cadence      = c;
        not_pedaling = np;
        in_vld       = v;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        in_vld = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic int exp_ramp(input int i);
`ifdef DESIRED_DRIVE_SLEW_LIMIT_EN
        return min2((i + 1) * 'h100, 'h600);
`else
        return 'h600;
`endif
    endfunction

    function automatic int exp_decay(input int i);
`ifdef DESIRED_DRIVE_SLEW_LIMIT_EN
        int v;
        v = 'h600 - (i + 1) * 'h200;
        return (v < 0) ? 0 : v;
`else
        return 0;
`endif
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx, cnt, pos;

        vecs[0] = '{12'h780, 3'd4, 13'd0,    5'd16, 1'b0, 12'h600, 1'b1};
        vecs[1] = '{12'hFFF, 3'd7, 13'h01FF, 5'd31, 1'b0, 12'hFFF, 1'b1};
        vecs[2] = '{12'h300, 3'd4, 13'd0,    5'd16, 1'b0, 12'h000, 1'b1};
        vecs[3] = '{12'h780, 3'd4, 13'd0,    5'd1,  1'b0, 12'h000, 1'b1};
        vecs[4] = '{12'h780, 3'd4, -13'sd300, 5'd16, 1'b0, 12'h000, 1'b1};
        vecs[5] = '{12'h780, 3'd4, 13'd0,    5'd16, 1'b1, 12'h000, 1'b0};
        vecs[6] = '{12'h480, 3'd2, 13'd0,    5'd2,  1'b0, 12'h088, 1'b1};
        vecs[7] = '{12'h780, 3'd0, 13'd0,    5'd16, 1'b0, 12'h000, 1'b1};
        vecs[8] = '{12'h580, 3'd1, 13'h0FFF, 5'd10, 1'b0, 12'h14F, 1'b1};
        vecs[9] = '{12'h780, 3'd1, 13'd255,  5'd30, 1'b0, 12'h3DE, 1'b1};

        drive(12'h0, 3'd0, 13'd0, 5'd0, 1'b0, 1'b0);
        do_reset();
        check("reset_target", target_curr, 0);
        check("reset_at_target", at_target, 0);
        check("reset_out_vld", out_vld, 0);

        // Ramp from reset with continuous samples
        drive(12'h780, 3'd4, 13'd0, 5'd16, 1'b0, 1'b1);
        idx = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_vld) begin
                check("ramp_seq", target_curr, exp_ramp(idx));
                idx++;
            end
        end
        check("ramp_count", idx, 18);
        check("ramp_at_target", at_target, 1);

        // Drain, then decay to idle with not_pedaling
        in_vld = 1'b0;
        for (int i = 0; i < 4; i++) step();
        drive(12'h780, 3'd4, 13'd0, 5'd16, 1'b1, 1'b1);
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_vld) begin
                check("decay_seq", target_curr, exp_decay(idx));
                idx++;
            end
        end
        check("decay_count", idx, 8);
        check("decay_idle", at_target, 0);

        // Single pulse latency
        in_vld = 1'b0;
        for (int i = 0; i < 4; i++) step();
        drive(12'h780, 3'd4, 13'd0, 5'd16, 1'b0, 1'b1);
        step();
        in_vld = 1'b0;
        cnt = 0;
        pos = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_vld) begin
                cnt++;
                pos = i;
            end
        end
        check("pulse_count", cnt, 1);
        check("pulse_pos", pos, 1);

        // Reset one cycle after a pulse discards it
        in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        rst_n  = 1'b0;
        step();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_vld) cnt++;
        end
        check("abort_count", cnt, 0);

        // Samples offered during reset are ignored
        rst_n  = 1'b0;
        in_vld = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rst_n  = 1'b1;
        in_vld = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_vld) cnt++;
        end
        check("in_reset_count", cnt, 0);

        // Converged targets for a table of operating points
        for (int v = 0; v < 10; v++) begin
            do_reset();
            drive(vecs[v].avg, vecs[v].sc, vecs[v].inc, vecs[v].cad, vecs[v].np, 1'b1);
            for (int i = 0; i < 20; i++) step();
            in_vld = 1'b0;
            for (int i = 0; i < 4; i++) step();
            check($sformatf("vec%0d_target", v), target_curr, vecs[v].exp_tgt);
            check($sformatf("vec%0d_at_target", v), at_target, vecs[v].exp_at);
        end

        // Random stimulus; operating point held for bursts so ramps complete sometimes
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                avg_torque   = 12'($urandom_range(0, 4095));
                scale        = 3'($urandom_range(0, 7));
                incline      = 13'($urandom_range(0, 8191));
                cadence      = 5'($urandom_range(0, 31));
                not_pedaling = ($urandom_range(0, 7) == 0);
            end
            in_vld = ($urandom_range(0, 9) < 7);
            rst_n  = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
